// File: rtl/sign_ext4_if.sv
// sign_ext4_if -- operand/result bundle for the sign_ext4 extender.
//   in        : operand, IN_W bits (two's-complement when sign-extending)
//   in_valid  : qualifies in and sext_en on the rising clock edge
//   sext_en   : 1 = sign extension, 0 = zero extension
//   out       : registered extended result, OUT_W bits
//   out_valid : one-cycle pulse per accepted operand
// master drives the operand side; slave is the extender itself.
interface sign_ext4_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic             sext_en;
  logic [OUT_W-1:0] out;
  logic             out_valid;

  modport master (
    output in,
    output in_valid,
    output sext_en,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in,
    input  in_valid,
    input  sext_en,
    output out,
    output out_valid
  );
endinterface

// File: rtl/sign_ext4.sv
// sign_ext4 -- registered sign/zero extender, one-cycle latency, no backpressure.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears out and out_valid)
//   bus : sign_ext4_if slave modport (in, in_valid, sext_en -> out, out_valid)
// The operand is widened combinationally and captured on every accepted edge;
// out holds its last value across idle cycles.
module sign_ext4 #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  sign_ext4_if.slave     bus
);

  // Reject impossible width combinations while elaborating.
  if ((IN_W < 1) || (OUT_W < IN_W) || (OUT_W > 64)) begin : g_bad_params
    $error("sign_ext4: illegal parameters IN_W=%0d OUT_W=%0d", IN_W, OUT_W);
  end

  logic [OUT_W-1:0] ext_s;
  logic             fill_s;
  logic [OUT_W-1:0] out_r;
  logic             out_valid_r;

  // Fill bit is the operand MSB only when sign extension is selected.
  assign fill_s = bus.sext_en & bus.in[IN_W-1];

  // Upper bits exist only when the result is wider than the operand.
  if (OUT_W > IN_W) begin : g_widen
    assign ext_s = {{(OUT_W-IN_W){fill_s}}, bus.in};
  end else begin : g_same
    assign ext_s = bus.in;
  end

  // Output register: capture on accepted edges, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r       <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        out_r <= ext_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_sign_ext4.sv
// tb_sign_ext4 -- scoreboard bench for sign_ext4 (16-bit and 4-bit-wide builds).
module tb_sign_ext4;

  logic clk;
  logic rst;

  sign_ext4_if #(.IN_W(4), .OUT_W(16)) a_if ();
  sign_ext4_if #(.IN_W(4), .OUT_W(4))  b_if ();

  sign_ext4 #(.IN_W(4), .OUT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  sign_ext4 #(.IN_W(4), .OUT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_a_q[$];
  logic [3:0]  exp_b_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%04h required=0x%04h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  // Monitor for the 16-bit build: every out_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && a_if.out_valid) begin
      if (exp_a_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_valid actual=0x%04h required=no_output", a_if.out);
      end else begin
        check16("a_result", a_if.out, exp_a_q.pop_front());
      end
    end
  end

  // Monitor for the equal-width build.
  always @(negedge clk) begin
    if (!rst && b_if.out_valid) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_valid actual=0x%01h required=no_output", b_if.out);
      end else begin
        check16("b_result", {12'h000, b_if.out}, {12'h000, exp_b_q.pop_front()});
      end
    end
  end

  // Present one operand to the 16-bit build for one edge; push expectation if valid.
  task automatic send_a(input logic v, input logic [3:0] d, input logic s, input logic [15:0] exp_v);
    a_if.in       = d;
    a_if.in_valid = v;
    a_if.sext_en  = s;
    if (v && !rst) exp_a_q.push_back(exp_v);
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d, input logic s, input logic [3:0] exp_v);
    b_if.in       = d;
    b_if.in_valid = 1'b1;
    b_if.sext_en  = s;
    exp_b_q.push_back(exp_v);
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
  endtask

  logic [15:0] ref_v;

  initial begin
    rst           = 1'b1;
    a_if.in       = 4'h0;
    a_if.in_valid = 1'b0;
    a_if.sext_en  = 1'b0;
    b_if.in       = 4'h0;
    b_if.in_valid = 1'b0;
    b_if.sext_en  = 1'b0;

    #2;
    check16("reset_out", a_if.out, 16'h0000);
    check1("reset_valid", a_if.out_valid, 1'b0);

    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sign-extension sequence on consecutive cycles.
    send_a(1'b1, 4'b0000, 1'b1, 16'h0000);
    send_a(1'b1, 4'b0111, 1'b1, 16'h0007);
    send_a(1'b1, 4'b1000, 1'b1, 16'hFFF8);
    send_a(1'b1, 4'b1111, 1'b1, 16'hFFFF);
    send_a(1'b1, 4'b1010, 1'b1, 16'hFFFA);

    // Zero extension.
    send_a(1'b1, 4'b1000, 1'b0, 16'h0008);
    send_a(1'b1, 4'b1111, 1'b0, 16'h000F);

    // Valid gap: out holds 0x0007 while out_valid drops.
    send_a(1'b1, 4'b0111, 1'b1, 16'h0007);
    send_a(1'b0, 4'b1101, 1'b1, 16'h0000);
    check16("gap_hold_out", a_if.out, 16'h0007);
    check1("gap_valid_low", a_if.out_valid, 1'b0);
    send_a(1'b1, 4'b1010, 1'b1, 16'hFFFA);

    // Asynchronous reset between edges while out=0xFFFA.
    @(negedge clk);
    #1;
    check16("pre_reset_out", a_if.out, 16'hFFFA);
    rst = 1'b1;
    #1;
    check16("async_reset_out", a_if.out, 16'h0000);
    check1("async_reset_valid", a_if.out_valid, 1'b0);
    // An operand offered while reset is high must be discarded.
    a_if.in       = 4'b1111;
    a_if.sext_en  = 1'b1;
    a_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
    check16("reset_discard_out", a_if.out, 16'h0000);
    check1("reset_discard_valid", a_if.out_valid, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check1("post_reset_idle_valid", a_if.out_valid, 1'b0);

    // First input after reset is accepted normally.
    send_a(1'b1, 4'b0101, 1'b1, 16'h0005);

    // Equal-width build: no replicated bits in either mode.
    send_b(4'b1010, 1'b1, 4'b1010);
    send_b(4'b0111, 1'b0, 4'b0111);
    send_b(4'b1001, 1'b1, 4'b1001);

    // Exhaustive sweep against a reference model, back-to-back.
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] d;
        d = c[3:0];
        if (m == 1) ref_v = {{12{d[3]}}, d};
        else        ref_v = {12'h000, d};
        send_a(1'b1, d, m[0], ref_v);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check16("a_all_results_seen", 16'(exp_a_q.size()), 16'h0000);
    check16("b_all_results_seen", 16'(exp_b_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sign_ext4.md
SIGN_EXT4 -- requirements
Module: sign_ext4

Interface
- REQ-001: Parameter IN_W, default 4: width of the input operand; legal range 1..OUT_W.
- REQ-002: Parameter OUT_W, default 16: width of the extended result; legal range IN_W..64.
- REQ-003: Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1: asynchronous, active-high reset.
- REQ-005: Port in, input, IN_W: operand, two's-complement when sign-extending.
- REQ-006: Port in_valid, input, 1: qualifies in; sampled on the rising edge of clk.
- REQ-007: Port sext_en, input, 1: 1 selects sign extension, 0 selects zero extension; sampled with in.
- REQ-008: Port out, output, OUT_W: registered extended result.
- REQ-009: Port out_valid, output, 1: high for exactly one cycle per accepted input.

Function
- REQ-010: On each rising edge with in_valid=1, sign_ext4 SHALL capture in and sext_en and, one cycle later, present the result on out with out_valid=1.
- REQ-011: Latency SHALL be exactly one clock, from the accepting edge to out/out_valid valid after that edge; throughput SHALL be one result per cycle, with no backpressure.
- REQ-012: With sext_en=1, out[IN_W-1:0] SHALL equal in, and out[OUT_W-1:IN_W] SHALL replicate in[IN_W-1].
- REQ-013: With sext_en=0, out[IN_W-1:0] SHALL equal in, and out[OUT_W-1:IN_W] SHALL be all zeros.
- REQ-014: When IN_W equals OUT_W, out SHALL equal in for either mode, with no replicated bits.
- REQ-015: On a rising edge with in_valid=0, out_valid SHALL go 0 and out SHALL hold its last value.
- REQ-016: Back-to-back valid inputs SHALL produce back-to-back results in order, each one cycle after its input.
- REQ-017: Illegal parameter combinations (OUT_W < IN_W, or IN_W < 1) SHALL be flagged at elaboration by a generate-time error.
- REQ-018: The extension datapath SHALL be purely combinational ahead of the output register, with no other internal state.

Reset
- REQ-019: While rst=1, out SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
- REQ-020: An input presented on the same edge on which rst is asserted, or while rst is high, SHALL be discarded.
- REQ-021: After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.
- REQ-022: If rst is asserted mid-stream, the pending result SHALL be lost, and out_valid SHALL stay 0 until a new input is accepted.

Verification
- REQ-023: Default parameters, sext_en=1, in sequence 0000, 0111, 1000, 1111, 1010 on consecutive cycles -> out 0x0000, 0x0007, 0xFFF8, 0xFFFF, 0xFFFA on the following cycles, out_valid=1 each cycle.
- REQ-024: sext_en=0, in=1000 then 1111 -> out 0x0008 then 0x000F.
- REQ-025: rst pulsed asynchronously between edges while out=0xFFFA -> out=0x0000 and out_valid=0 at once, before the next clk edge.
- REQ-026: in_valid pattern 1,0,1 with in=0111, xxxx, 1010 -> out_valid pattern 1,0,1; out holds 0x0007 during the gap, then becomes 0xFFFA.
- REQ-027: IN_W=4, OUT_W=4, in=1010 with sext_en=1 -> out=1010.
- REQ-028: All 16 input codes × both modes against a reference model -> zero mismatches, with out_valid asserted exactly once per input.
